// File: rtl/y_capture_pkg.sv
// Shared types and MISR step for the Y-capture block.
// Optional golden comparison is enabled by defining Y_CAPTURE_GOLDEN_EN.
package y_capture_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [15:0] POLY_16 = 16'h100B;

    // MSB-first Galois step; the sample is folded into the low bits after the shift.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] y);
        return {sig[14:0], 1'b0} ^ (sig[15] ? POLY_16 : 16'h0000) ^ y;
    endfunction

endpackage

// File: rtl/y_capture_fifo.sv
// Small synchronous FIFO; head reads straight from the registered storage.
// Extra pointer MSB distinguishes full from empty when the indices match.
module y_capture_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/y_capture_misr.sv
// Captures a run of Y samples into a 16-bit MISR and forwards each one through a FIFO.
// Define Y_CAPTURE_GOLDEN_EN to add the golden_sig input and registered pass flag.
module y_capture_misr
    import y_capture_pkg::*;
#(
    parameter int Y_W   = 3,
    parameter int DEPTH = 2,
    parameter int SIG_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Y_W-1:0]   in_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Y_W-1:0]   out_y,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] signature
`ifdef Y_CAPTURE_GOLDEN_EN
    ,
    input  logic [SIG_W-1:0] golden_sig,
    output logic             pass
`endif
);

    state_e           state_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] count_q;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic             busy_q;
    logic             done_q;
    logic             accept;
    logic             last;
    logic             fifo_full;
    logic             fifo_empty;

    // A full FIFO stalls the input even on a same-cycle pop: no bypass path.
    assign in_ready  = (state_q == RUN) && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign last      = (count_q == n_q - CNT_W'(1));
    assign sig_d     = misr_step(sig_q, 16'(in_y));
    assign out_valid = !fifo_empty;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;

`ifdef Y_CAPTURE_GOLDEN_EN
    logic pass_q;
    assign pass = pass_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            n_q     <= '0;
            count_q <= '0;
            sig_q   <= '0;
`ifdef Y_CAPTURE_GOLDEN_EN
            pass_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        n_q     <= n_samples;
                        count_q <= '0;
                        sig_q   <= '0;
                        if (n_samples == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`ifdef Y_CAPTURE_GOLDEN_EN
                            pass_q  <= (golden_sig == '0);
`endif
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
`ifdef Y_CAPTURE_GOLDEN_EN
                            pass_q  <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        count_q <= count_q + CNT_W'(1);
                        sig_q   <= sig_d;
                        if (last) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`ifdef Y_CAPTURE_GOLDEN_EN
                            pass_q  <= (sig_d == golden_sig);
`endif
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    y_capture_fifo #(
        .W     (Y_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   (in_y),
        .pop   (out_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (out_y)
    );

endmodule

// File: tb/tb_y_capture_misr.sv
// Directed bench for y_capture_misr: reset, MISR values, backpressure, zero-length and restart runs.
module tb_y_capture_misr;

    localparam int Y_W   = 3;
    localparam int DEPTH = 2;
    localparam int SIG_W = 16;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] n_samples;
    logic             in_valid;
    logic             in_ready;
    logic [Y_W-1:0]   in_y;
    logic             out_valid;
    logic             out_ready;
    logic [Y_W-1:0]   out_y;
    logic             busy;
    logic             done;
    logic [SIG_W-1:0] signature;
`ifdef Y_CAPTURE_GOLDEN_EN
    logic [SIG_W-1:0] golden_sig;
    logic             pass;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    y_capture_misr #(
        .Y_W   (Y_W),
        .DEPTH (DEPTH),
        .SIG_W (SIG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_samples (n_samples),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy),
        .done      (done),
        .signature (signature)
`ifdef Y_CAPTURE_GOLDEN_EN
        ,
        .golden_sig(golden_sig),
        .pass      (pass)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] outs;
        rst_n = 1'b0; start = 1'b0; n_samples = '0; in_valid = 1'b0; in_y = '0; out_ready = 1'b0;
`ifdef Y_CAPTURE_GOLDEN_EN
        golden_sig = '0;
`endif
        repeat (3) step();
        outs = {in_ready, out_valid, out_y, busy, done, signature};
        total++;
        if (outs !== 26'd0) begin bad++; $display("FAIL reset_outs: got %h exp 0", outs); end
        rst_n = 1'b1;
        step(); step();
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: in_ready=%b busy=%b exp 0 0", in_ready, busy);
        end
        start = 1'b1; n_samples = 8'd5;
        step();
        start = 1'b0; in_valid = 1'b1; in_y = 3'd6;
        step();
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || signature !== 16'h0006) begin
            bad++; $display("FAIL midrun_pre: busy=%b out_valid=%b sig=%h exp 1 1 0006", busy, out_valid, signature);
        end
        #2 rst_n = 1'b0;
        #1;
        outs = {in_ready, out_valid, out_y, busy, done, signature};
        total++;
        if (outs !== 26'd0) begin bad++; $display("FAIL midrun_reset_outs: got %h exp 0", outs); end
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL after_abort: in_ready=%b out_valid=%b done=%b exp 0 0 0", in_ready, out_valid, done);
        end
    endtask

    task automatic test_misr();
        out_ready = 1'b1;
        start = 1'b1; n_samples = 8'd2;
        step();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || signature !== 16'h0000) begin
            bad++; $display("FAIL misr_start: busy=%b in_ready=%b sig=%h exp 1 1 0000", busy, in_ready, signature);
        end
        in_valid = 1'b1; in_y = 3'b101;
        step();
        total++;
        if (signature !== 16'h0005 || out_valid !== 1'b1 || out_y !== 3'b101 || done !== 1'b0) begin
            bad++; $display("FAIL misr_first: sig=%h ov=%b y=%b done=%b exp 0005 1 101 0", signature, out_valid, out_y, done);
        end
        in_y = 3'b011;
        step();
        total++;
        if (signature !== 16'h0009 || done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL misr_second: sig=%h done=%b busy=%b rdy=%b exp 0009 1 0 0", signature, done, busy, in_ready);
        end
        total++;
        if (out_valid !== 1'b1 || out_y !== 3'b011) begin
            bad++; $display("FAIL misr_fifo_head: ov=%b y=%b exp 1 011", out_valid, out_y);
        end
        in_valid = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b0 || signature !== 16'h0009 || done !== 1'b1) begin
            bad++; $display("FAIL misr_frozen: ov=%b sig=%h done=%b exp 0 0009 1", out_valid, signature, done);
        end
    endtask

    task automatic test_poly();
        int idx = 0;
        int cyc = 0;
        out_ready = 1'b1; in_valid = 1'b0;
        start = 1'b1; n_samples = 8'd17;
        step();
        start = 1'b0;
        while (idx < 17 && cyc < 40) begin
            logic acc;
            in_valid = 1'b1;
            in_y = (idx == 0) ? 3'd1 : 3'd0;
            acc = in_ready;
            step();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == 16) begin
                    total++;
                    if (signature !== 16'h8000) begin bad++; $display("FAIL poly_msb: got %h exp 8000", signature); end
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (idx != 17 || cyc != 17) begin bad++; $display("FAIL poly_accepts: got %0d in %0d cycles exp 17 in 17", idx, cyc); end
        total++;
        if (signature !== 16'h100B || done !== 1'b1) begin
            bad++; $display("FAIL poly_feedback: sig=%h done=%b exp 100b 1", signature, done);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [2:0] ys [4] = '{3'd1, 3'd6, 3'd3, 3'd7};
        logic [2:0] got [4];
        int idx = 0;
        int nout = 0;
        int cyc = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
        start = 1'b1; n_samples = 8'd4;
        step();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            logic acc;
            in_valid = (idx < 4);
            in_y = ys[idx & 3];
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        total++;
        if (idx != 2 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall: accepts=%0d rdy=%b exp 2 0", idx, in_ready); end
        total++;
        if (out_y !== 3'd1 || signature !== 16'h0004) begin
            bad++; $display("FAIL bp_hold: y=%0d sig=%h exp 1 0004", out_y, signature);
        end
        out_ready = 1'b1;
        while (nout < 4 && cyc < 30) begin
            logic acc;
            logic pp;
            logic [2:0] hv;
            in_valid = (idx < 4);
            in_y = ys[idx & 3];
            acc = in_valid && in_ready;
            pp = out_valid && out_ready;
            hv = out_y;
            step();
            cyc++;
            if (acc) idx++;
            if (pp) begin got[nout] = hv; nout++; end
        end
        in_valid = 1'b0;
        total++;
        if (nout != 4 || idx != 4) begin bad++; $display("FAIL bp_counts: pops=%0d accepts=%0d exp 4 4", nout, idx); end
        for (int k = 0; k < nout; k++) begin
            total++;
            if (got[k] !== ys[k]) begin bad++; $display("FAIL bp_order[%0d]: got %0d exp %0d", k, got[k], ys[k]); end
        end
        total++;
        if (signature !== 16'h0011 || done !== 1'b1) begin
            bad++; $display("FAIL bp_final: sig=%h done=%b exp 0011 1", signature, done);
        end
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1; in_valid = 1'b1; in_y = 3'd5;
        start = 1'b1; n_samples = 8'd0;
        step();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || signature !== 16'h0000) begin
            bad++; $display("FAIL zero_len: done=%b busy=%b rdy=%b sig=%h exp 1 0 0 0000", done, busy, in_ready, signature);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_len_noaccept: ov=%b exp 0", out_valid); end
        in_valid = 1'b0;
    endtask

    task automatic test_restart();
        out_ready = 1'b1; in_valid = 1'b0;
        start = 1'b1; n_samples = 8'd3;
        step();
        start = 1'b0; in_valid = 1'b1; in_y = 3'd5;
        step();
        total++;
        if (signature !== 16'h0005) begin bad++; $display("FAIL restart_first: got %h exp 0005", signature); end
        start = 1'b1; n_samples = 8'd9; in_y = 3'd3;
        step();
        start = 1'b0;
        total++;
        if (signature !== 16'h0009 || busy !== 1'b1) begin
            bad++; $display("FAIL start_in_run: sig=%h busy=%b exp 0009 1", signature, busy);
        end
        in_y = 3'd1;
        step();
        total++;
        if (signature !== 16'h0013 || done !== 1'b1) begin
            bad++; $display("FAIL start_ignored_len: sig=%h done=%b exp 0013 1", signature, done);
        end
        in_valid = 1'b0;
        start = 1'b1; n_samples = 8'd1;
        step();
        start = 1'b0;
        total++;
        if (signature !== 16'h0000 || busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL start_in_done: sig=%h busy=%b done=%b exp 0000 1 0", signature, busy, done);
        end
        in_valid = 1'b1; in_y = 3'd2;
        step();
        in_valid = 1'b0;
        total++;
        if (signature !== 16'h0002 || done !== 1'b1) begin
            bad++; $display("FAIL rerun_done: sig=%h done=%b exp 0002 1", signature, done);
        end
        step();
    endtask

`ifdef Y_CAPTURE_GOLDEN_EN
    task automatic test_golden();
        logic [15:0] goldens [2] = '{16'h0009, 16'h0008};
        logic        exp_pass [2] = '{1'b1, 1'b0};
        out_ready = 1'b1;
        for (int g = 0; g < 2; g++) begin
            golden_sig = goldens[g];
            start = 1'b1; n_samples = 8'd2;
            step();
            start = 1'b0;
            total++;
            if (pass !== 1'b0) begin bad++; $display("FAIL golden_clear[%0d]: got %b exp 0", g, pass); end
            in_valid = 1'b1; in_y = 3'b101;
            step();
            in_y = 3'b011;
            step();
            in_valid = 1'b0;
            total++;
            if (pass !== exp_pass[g] || done !== 1'b1) begin
                bad++; $display("FAIL golden_pass[%0d]: pass=%b done=%b exp %b 1", g, pass, done, exp_pass[g]);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_misr();
        test_poly();
        test_backpressure();
        test_zero_len();
        test_restart();
`ifdef Y_CAPTURE_GOLDEN_EN
        test_golden();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
